// File: rtl/pci_cfg_space.sv
// ============================================================================
//  Module      : pci_cfg_space
//  Description : PCI type-0 configuration space for an EDU-class endpoint.
//                Single-cycle ack handshake; byte-enabled writes; sticky
//                W1C status; up to six sized 32-bit memory BARs.
//                Optional MSI capability when PCI_CFG_MSI_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_cfg_space #(
    parameter logic [15:0] VENDOR_ID     = 16'h1234,
    parameter logic [15:0] DEVICE_ID     = 16'h11e8,
    parameter logic [31:0] CLASS_REV     = 32'hff000009,
    parameter int          NUM_BARS      = 1,
    parameter int          BAR_SIZE_LOG2 = 20,
    parameter logic [31:0] SUBSYS_ID_DEF = 32'h11e81234,
    parameter logic [7:0]  INT_PIN       = 8'h01
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic                    cfg_iswrite,
    input  logic [5:0]              cfg_offset,
    input  logic [3:0]              cfg_byte_en,
    input  logic [31:0]             cfg_write_val,
    output logic [31:0]             cfg_read_val,
    output logic                    cfg_ack,
    input  logic                    intr_status,
    input  logic [5:0]              status_evt,
    output logic [10:0]             command,
`ifdef PCI_CFG_MSI_EN
    output logic                    msi_enable,
    output logic [31:0]             msi_addr,
    output logic [15:0]             msi_data,
`endif
    output logic [32*NUM_BARS-1:0]  bar_base
);

    // Writable command bits: 0-4, 6, 8-10 (bit 5 VGA snoop and bit 7 stepping are hardwired 0)
    localparam logic [10:0] c_cmd_mask = 11'h75f;
    localparam logic [31:0] c_bar_mask = ~((32'd1 << BAR_SIZE_LOG2) - 32'd1);
`ifdef PCI_CFG_MSI_EN
    localparam logic [7:0]  c_cap_ptr  = 8'h40;
    localparam logic        c_cap_flag = 1'b1;
`else
    localparam logic [7:0]  c_cap_ptr  = 8'h00;
    localparam logic        c_cap_flag = 1'b0;
`endif

    logic               r_ack;
    logic [31:0]        r_rd_val;
    logic [10:0]        r_command;
    logic [5:0]         r_sts;          // sticky bits in status_evt order
    logic [7:0]         r_cache;
    logic [4:0]         r_lat;
    logic [31:0]        r_subsys;
    logic [7:0]         r_int_line;
`ifdef PCI_CFG_MSI_EN
    logic               r_msi_en;
    logic [29:0]        r_msi_addr;
    logic [15:0]        r_msi_data;
`endif

    logic               w_wr;
    logic               w_rd;
    logic [15:0]        w_status;
    logic [5:0]         w_sts_clr;
    logic [31:0]        w_rd_data;
    logic [31:0]        w_merged;
    logic [5:0][31:0]   w_bar_rd;

    assign w_wr = cfg_enable &  cfg_iswrite;
    assign w_rd = cfg_enable & ~cfg_iswrite;

    // {dpe, sse, rma, rta, sta, devsel=00, mdpe, 000, cap, intr, 000}
    assign w_status = {r_sts[5], r_sts[4], r_sts[3], r_sts[2], r_sts[1], 2'b00,
                       r_sts[0], 3'b000, c_cap_flag, intr_status, 3'b000};

    // Status only lives in byte 3 of dword 0x01; map W1C data bits back to sticky order
    assign w_sts_clr = (w_wr && cfg_offset == 6'h01 && cfg_byte_en[3]) ?
                       {cfg_write_val[31], cfg_write_val[30], cfg_write_val[29],
                        cfg_write_val[28], cfg_write_val[27], cfg_write_val[24]} : 6'b0;

    // Dword read mux: everything not listed reads zero
    always_comb begin
        w_rd_data = 32'h0;
        case (cfg_offset)
            6'h00: w_rd_data = {DEVICE_ID, VENDOR_ID};
            6'h01: w_rd_data = {w_status, 5'b0, r_command};
            6'h02: w_rd_data = CLASS_REV;
            6'h03: w_rd_data = {16'h0, r_lat, 3'b000, r_cache};
            6'h04: w_rd_data = w_bar_rd[0];
            6'h05: w_rd_data = w_bar_rd[1];
            6'h06: w_rd_data = w_bar_rd[2];
            6'h07: w_rd_data = w_bar_rd[3];
            6'h08: w_rd_data = w_bar_rd[4];
            6'h09: w_rd_data = w_bar_rd[5];
            6'h0b: w_rd_data = r_subsys;
            6'h0d: w_rd_data = {24'h0, c_cap_ptr};
            6'h0f: w_rd_data = {16'h0, INT_PIN, r_int_line};
`ifdef PCI_CFG_MSI_EN
            6'h10: w_rd_data = {15'h0, r_msi_en, 8'h00, 8'h05};
            6'h11: w_rd_data = {r_msi_addr, 2'b00};
            6'h12: w_rd_data = {16'h0, r_msi_data};
`endif
            default: w_rd_data = 32'h0;
        endcase
    end

    // Byte-merge write data into the current dword contents; bytes without an enable keep their value
    always_comb begin
        w_merged = w_rd_data;
        for (int b = 0; b < 4; b++) begin
            if (cfg_byte_en[b]) begin
                w_merged[8*b +: 8] = cfg_write_val[8*b +: 8];
            end
        end
    end

    // Handshake, read data capture and all non-BAR writable registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack      <= 1'b0;
            r_rd_val   <= 32'h0;
            r_command  <= 11'h0;
            r_sts      <= 6'h0;
            r_cache    <= 8'h0;
            r_lat      <= 5'h0;
            r_subsys   <= SUBSYS_ID_DEF;
            r_int_line <= 8'h0;
`ifdef PCI_CFG_MSI_EN
            r_msi_en   <= 1'b0;
            r_msi_addr <= 30'h0;
            r_msi_data <= 16'h0;
`endif
        end else begin
            r_ack <= cfg_enable;
            if (w_rd) begin
                r_rd_val <= w_rd_data;
            end
            // A new event outranks a simultaneous W1C clear
            r_sts <= (r_sts & ~w_sts_clr) | status_evt;
            if (w_wr) begin
                case (cfg_offset)
                    6'h01: r_command  <= w_merged[10:0] & c_cmd_mask;
                    6'h03: begin
                        r_cache <= w_merged[7:0];
                        r_lat   <= w_merged[15:11];
                    end
                    6'h0b: r_subsys   <= w_merged;
                    6'h0f: r_int_line <= w_merged[7:0];
`ifdef PCI_CFG_MSI_EN
                    6'h10: r_msi_en   <= w_merged[16];
                    6'h11: r_msi_addr <= w_merged[31:2];
                    6'h12: r_msi_data <= w_merged[15:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // One register per implemented BAR; unimplemented slots read zero
    for (genvar g = 0; g < 6; g++) begin : g_bar
        if (g < NUM_BARS) begin : g_impl
            localparam logic [5:0] c_off = 6'(4 + g);
            logic [31:0] r_bar;

            // BAR base: only the size-aligned upper bits are kept
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_bar <= 32'h0;
                end else if (w_wr && cfg_offset == c_off) begin
                    r_bar <= w_merged & c_bar_mask;
                end
            end

            assign w_bar_rd[g]          = r_bar;
            assign bar_base[32*g +: 32] = r_bar;
        end else begin : g_none
            assign w_bar_rd[g] = 32'h0;
        end
    end

    assign cfg_ack      = r_ack;
    assign cfg_read_val = r_rd_val;
    assign command      = r_command;
`ifdef PCI_CFG_MSI_EN
    assign msi_enable   = r_msi_en;
    assign msi_addr     = {r_msi_addr, 2'b00};
    assign msi_data     = r_msi_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pci_cfg_space.sv
// ============================================================================
//  Module      : tb_pci_cfg_space
//  Description : Directed self-checking bench for pci_cfg_space
//                (NUM_BARS=2, BAR_SIZE_LOG2=20). MSI checks are selected by
//                PCI_CFG_MSI_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pci_cfg_space;

`ifdef PCI_CFG_MSI_EN
    localparam logic [31:0] CAP = 32'h0010_0000;
`else
    localparam logic [31:0] CAP = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_enable = 1'b0;
    logic        cfg_iswrite = 1'b0;
    logic [5:0]  cfg_offset = 6'h0;
    logic [3:0]  cfg_byte_en = 4'h0;
    logic [31:0] cfg_write_val = 32'h0;
    logic [31:0] cfg_read_val;
    logic        cfg_ack;
    logic        intr_status = 1'b0;
    logic [5:0]  status_evt = 6'h0;
    logic [10:0] command;
    logic [63:0] bar_base;
`ifdef PCI_CFG_MSI_EN
    logic        msi_enable;
    logic [31:0] msi_addr;
    logic [15:0] msi_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    pci_cfg_space #(
        .NUM_BARS      (2),
        .BAR_SIZE_LOG2 (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_iswrite   (cfg_iswrite),
        .cfg_offset    (cfg_offset),
        .cfg_byte_en   (cfg_byte_en),
        .cfg_write_val (cfg_write_val),
        .cfg_read_val  (cfg_read_val),
        .cfg_ack       (cfg_ack),
        .intr_status   (intr_status),
        .status_evt    (status_evt),
        .command       (command),
`ifdef PCI_CFG_MSI_EN
        .msi_enable    (msi_enable),
        .msi_addr      (msi_addr),
        .msi_data      (msi_data),
`endif
        .bar_base      (bar_base)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read: drive on negedge, sample ack and data on the following negedge
    task automatic cfg_rd(input logic [5:0] off, output logic [31:0] data);
        @(negedge clk);
        cfg_enable = 1'b1; cfg_iswrite = 1'b0; cfg_offset = off;
        @(negedge clk);
        cfg_enable = 1'b0;
        chk("rd_ack", {63'b0, cfg_ack}, 64'd1);
        data = cfg_read_val;
    endtask

    task automatic cfg_wr(input logic [5:0] off, input logic [3:0] be, input logic [31:0] val);
        @(negedge clk);
        cfg_enable = 1'b1; cfg_iswrite = 1'b1; cfg_offset = off;
        cfg_byte_en = be; cfg_write_val = val;
        @(negedge clk);
        cfg_enable = 1'b0; cfg_iswrite = 1'b0; cfg_byte_en = 4'h0;
        chk("wr_ack", {63'b0, cfg_ack}, 64'd1);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ack",     {63'b0, cfg_ack}, 64'd0);
        chk("rst_rdval",   {32'b0, cfg_read_val}, 64'd0);
        chk("rst_command", {53'b0, command}, 64'd0);
        chk("rst_bar",     bar_base, 64'd0);
        rst = 1'b1;

        // ID reads and single-cycle ack
        cfg_rd(6'h00, rd);
        chk("rd_id", {32'b0, rd}, 64'h11e81234);
        @(negedge clk);
        chk("ack_pulse", {63'b0, cfg_ack}, 64'd0);
        chk("rdval_hold", {32'b0, cfg_read_val}, 64'h11e81234);
        cfg_rd(6'h01, rd);
        chk("rd_cmdsts", {32'b0, rd}, {32'b0, CAP});
        cfg_rd(6'h02, rd);
        chk("rd_class", {32'b0, rd}, 64'hff000009);

        // BAR sizing and base
        cfg_wr(6'h04, 4'hf, 32'hffffffff);
        cfg_rd(6'h04, rd);
        chk("bar_size", {32'b0, rd}, 64'hfff00000);
        cfg_wr(6'h04, 4'hf, 32'hfeb12345);
        chk("bar_base0", bar_base, 64'h00000000_feb00000);
        cfg_wr(6'h05, 4'hf, 32'h80012345);
        chk("bar_base1", bar_base, 64'h80000000_feb00000);
        cfg_wr(6'h06, 4'hf, 32'hffffffff);
        cfg_rd(6'h06, rd);
        chk("bar2_absent", {32'b0, rd}, 64'd0);

        // Command byte enables
        cfg_wr(6'h01, 4'b0001, 32'h0000_0406);
        chk("cmd_be0", {53'b0, command}, 64'h006);
        cfg_rd(6'h01, rd);
        chk("cmd_rd", {32'b0, rd}, {32'b0, CAP | 32'h0000_0006});
        cfg_wr(6'h01, 4'b0010, 32'h0000_0406);
        chk("cmd_be1", {53'b0, command}, 64'h406);
        cfg_wr(6'h01, 4'b0011, 32'h0000_ffff);
        chk("cmd_mask", {53'b0, command}, 64'h75f);
        cfg_wr(6'h01, 4'b0011, 32'h0000_0406);

        // Sticky status, W1C, set-wins
        @(negedge clk); status_evt = 6'b001000;
        @(negedge clk); status_evt = 6'b000000;
        cfg_rd(6'h01, rd);
        chk("sts_rma_set", {32'b0, rd}, {32'b0, CAP | 32'h2000_0406});
        cfg_wr(6'h01, 4'b1000, 32'h2000_0000);
        cfg_rd(6'h01, rd);
        chk("sts_rma_clr", {32'b0, rd}, {32'b0, CAP | 32'h0000_0406});
        @(negedge clk); status_evt = 6'b001000;
        cfg_wr(6'h01, 4'b1000, 32'h2000_0000);
        status_evt = 6'b000000;
        cfg_rd(6'h01, rd);
        chk("sts_set_wins", {32'b0, rd}, {32'b0, CAP | 32'h2000_0406});
        // W1C with byte enable off must not clear
        cfg_wr(6'h01, 4'b0111, 32'hffff_0406);
        cfg_rd(6'h01, rd);
        chk("sts_be_off", {32'b0, rd}, {32'b0, CAP | 32'h2000_0406});
        @(negedge clk); status_evt = 6'b100001; intr_status = 1'b1;
        @(negedge clk); status_evt = 6'b000000;
        cfg_rd(6'h01, rd);
        chk("sts_dpe_mdpe_int", {32'b0, rd}, {32'b0, CAP | 32'ha108_0406});
        intr_status = 1'b0;

        // Cache line / latency timer
        cfg_wr(6'h03, 4'hf, 32'hffffffff);
        cfg_rd(6'h03, rd);
        chk("cache_lat", {32'b0, rd}, 64'h0000f8ff);

        // Back-to-back read 0x0b then write 0x0f
        @(negedge clk);
        cfg_enable = 1'b1; cfg_iswrite = 1'b0; cfg_offset = 6'h0b;
        @(negedge clk);
        chk("b2b_ack1", {63'b0, cfg_ack}, 64'd1);
        chk("b2b_rd", {32'b0, cfg_read_val}, 64'h11e81234);
        cfg_iswrite = 1'b1; cfg_offset = 6'h0f; cfg_byte_en = 4'hf; cfg_write_val = 32'h0000_000b;
        @(negedge clk);
        cfg_enable = 1'b0; cfg_iswrite = 1'b0; cfg_byte_en = 4'h0;
        chk("b2b_ack2", {63'b0, cfg_ack}, 64'd1);
        chk("b2b_hold", {32'b0, cfg_read_val}, 64'h11e81234);
        @(negedge clk);
        chk("b2b_ack_end", {63'b0, cfg_ack}, 64'd0);
        cfg_rd(6'h0f, rd);
        chk("int_line", {32'b0, rd}, 64'h0000010b);

        // Unmapped offset
        cfg_wr(6'h3f, 4'hf, 32'hdeadbeef);
        cfg_rd(6'h3f, rd);
        chk("unmapped", {32'b0, rd}, 64'd0);
        cfg_rd(6'h0a, rd);
        chk("rd_0a", {32'b0, rd}, 64'd0);

`ifdef PCI_CFG_MSI_EN
        cfg_rd(6'h0d, rd);
        chk("cap_ptr", {32'b0, rd}, 64'h40);
        cfg_wr(6'h11, 4'hf, 32'hfee00003);
        cfg_wr(6'h12, 4'hf, 32'hffff4021);
        cfg_wr(6'h10, 4'b0100, 32'hffff_ffff);
        chk("msi_en", {63'b0, msi_enable}, 64'd1);
        chk("msi_addr", {32'b0, msi_addr}, 64'hfee00000);
        chk("msi_data", {48'b0, msi_data}, 64'h4021);
        cfg_rd(6'h10, rd);
        chk("msi_ctrl_rd", {32'b0, rd}, 64'h00010005);
        cfg_rd(6'h12, rd);
        chk("msi_data_rd", {32'b0, rd}, 64'h00004021);
`else
        cfg_rd(6'h0d, rd);
        chk("cap_ptr", {32'b0, rd}, 64'd0);
        cfg_wr(6'h10, 4'hf, 32'hffffffff);
        cfg_rd(6'h10, rd);
        chk("msi_absent", {32'b0, rd}, 64'd0);
`endif

        // Reset mid-sequence with a concurrent write: dropped, no ack
        cfg_wr(6'h0b, 4'hf, 32'hcafef00d);
        @(negedge clk);
        rst = 1'b0;
        cfg_enable = 1'b1; cfg_iswrite = 1'b1; cfg_offset = 6'h01;
        cfg_byte_en = 4'hf; cfg_write_val = 32'h0000_0007;
        @(negedge clk);
        cfg_enable = 1'b0; cfg_iswrite = 1'b0; cfg_byte_en = 4'h0;
        chk("rst2_ack", {63'b0, cfg_ack}, 64'd0);
        chk("rst2_cmd", {53'b0, command}, 64'd0);
        chk("rst2_bar", bar_base, 64'd0);
        chk("rst2_rdval", {32'b0, cfg_read_val}, 64'd0);
`ifdef PCI_CFG_MSI_EN
        chk("rst2_msi", {15'b0, msi_enable, msi_addr, msi_data}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        cfg_rd(6'h0b, rd);
        chk("rst2_subsys", {32'b0, rd}, 64'h11e81234);
        cfg_rd(6'h01, rd);
        chk("rst2_sts", {32'b0, rd}, {32'b0, CAP});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
